// File: rtl/aes_pkg.sv
// Shared AES definitions for the key schedule and cipher datapaths.
//   SBOX    : forward AES S-box, indexed by the input byte
//   sbox()  : byte substitution through SBOX
//   rcon()  : round constant Rcon[1..10]; 0 outside that range
//   nr_of() : number of rounds for a key of nk 32-bit words
//   rot_word() : cyclic left rotate of a word by one byte
//   kx_state_t : key-expansion sequencing states
package aes_pkg;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {
        KX_LOAD,
        KX_EXPAND,
        KX_DONE
    } kx_state_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic int unsigned nr_of(input int unsigned nk);
        return nk + 6;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box for one byte.
//   a : input byte
//   s : substituted byte
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] s
);

    assign s = sbox(a);

endmodule

// File: rtl/key_expansion.sv
// Iterative AES key schedule (AES-128/192/256 by nk), one 32-bit word per clock.
//   clk     : rising-edge clock
//   reset   : asynchronous active-high reset; clears the whole schedule
//   key     : cipher key, w0 in the top 32 bits; sampled on the first edge after reset
//   outKeys : full schedule, word k at outKeys[32*NW-1-32*k -: 32]; words not yet
//             computed read 0. Complete 1+NW-nk edges after reset release.
module key_expansion
    import aes_pkg::*;
#(
    parameter  int unsigned nk = 4,
    localparam int unsigned nr = nr_of(nk),
    localparam int unsigned NW = 4 * (nr + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [32*nk-1:0]    key,
    output logic [32*NW-1:0]    outKeys
);

    localparam int unsigned CW = $clog2(NW + 1);
    localparam int unsigned PW = $clog2(nk);

    kx_state_t      state;
    logic [CW-1:0]  cnt;      // index i of the next word to compute
    logic [PW-1:0]  pos;      // i % nk, tracked incrementally
    logic [3:0]     rnd;      // i / nk, selects Rcon when pos == 0
    logic [31:0]    w [NW];

    logic [31:0]    prev;
    logic [31:0]    old;
    logic [31:0]    sub_in;
    logic [31:0]    sub_out;
    logic [31:0]    temp;

    // i%nk and i/nk are carried as a phase/round counter pair instead of
    // being divided out of cnt each cycle.
    always_comb begin
        prev   = w[cnt - CW'(1)];
        old    = w[cnt - CW'(nk)];
        sub_in = (pos == '0) ? rot_word(prev) : prev;
        if (pos == '0) begin
            temp = sub_out ^ {rcon(rnd), 24'h0};
        end else if (nk == 8 && 32'(pos) == 4) begin
            temp = sub_out;
        end else begin
            temp = prev;
        end
    end

    genvar b;
    generate
        for (b = 0; b < 4; b++) begin : g_sub
            aes_sbox u_sbox (
                .a (sub_in[8*b +: 8]),
                .s (sub_out[8*b +: 8])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= KX_LOAD;
            cnt   <= '0;
            pos   <= '0;
            rnd   <= '0;
            for (int unsigned k = 0; k < NW; k++) begin
                w[k] <= '0;
            end
        end else begin
            case (state)
                KX_LOAD: begin
                    for (int unsigned k = 0; k < nk; k++) begin
                        w[k] <= key[32*nk-1-32*k -: 32];
                    end
                    cnt   <= CW'(nk);
                    pos   <= '0;
                    rnd   <= 4'd1;
                    state <= KX_EXPAND;
                end
                KX_EXPAND: begin
                    w[cnt] <= old ^ temp;
                    cnt    <= cnt + CW'(1);
                    if (32'(pos) == nk - 1) begin
                        pos <= '0;
                        rnd <= rnd + 4'd1;
                    end else begin
                        pos <= pos + PW'(1);
                    end
                    if (cnt == CW'(NW - 1)) begin
                        state <= KX_DONE;
                    end
                end
                default: begin
                    // Done: schedule and counter hold until the next reset.
                end
            endcase
        end
    end

    genvar k;
    generate
        for (k = 0; k < NW; k++) begin : g_out
            assign outKeys[32*NW-1-32*k -: 32] = w[k];
        end
    endgenerate

endmodule

// File: tb/tb_key_expansion.sv
module tb_key_expansion;

    localparam int NW4 = 44;
    localparam int NW6 = 52;
    localparam int NW8 = 60;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [127:0]         key4 = '0;
    logic [191:0]         key6 = '0;
    logic [255:0]         key8 = '0;
    logic [32*NW4-1:0]    out4;
    logic [32*NW6-1:0]    out6;
    logic [32*NW8-1:0]    out8;

    always #5 clk = ~clk;

    key_expansion #(.nk(4)) dut4 (.clk(clk), .reset(reset), .key(key4), .outKeys(out4));
    key_expansion #(.nk(6)) dut6 (.clk(clk), .reset(reset), .key(key6), .outKeys(out6));
    key_expansion #(.nk(8)) dut8 (.clk(clk), .reset(reset), .key(key8), .outKeys(out8));

    typedef struct {
        int          which;
        int          word;
        logic [31:0] exp;
        string       tag;
    } item_t;

    item_t   sb_q [$];
    event    sample_ev;
    int      checks = 0;
    int      errors = 0;
    logic [7:0] tb_sbox [256];

    // ---------------- reference model (GF(2^8) arithmetic) ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p = '0;
        logic [7:0] aa = x;
        logic [7:0] bb = y;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = '0;
            logic [7:0] xv = 8'(x);
            for (int y = 1; y < 256; y++)
                if (x != 0 && gf_mul(xv, 8'(y)) == 8'h01) inv = 8'(y);
            tb_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {tb_sbox[x[31:24]], tb_sbox[x[23:16]], tb_sbox[x[15:8]], tb_sbox[x[7:0]]};
    endfunction

    function automatic void ref_expand(input int nk, input logic [255:0] k, output logic [31:0] w [60]);
        int nwords = 4 * (nk + 7);
        logic [7:0] rc = 8'h01;
        logic [31:0] t;
        for (int j = 0; j < 60; j++) w[j] = '0;
        for (int j = 0; j < nk; j++) w[j] = k[32*nk-1-32*j -: 32];
        for (int i = nk; i < nwords; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end else if (nk == 8 && i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
    endfunction

    // ---------------- scoreboard helpers ----------------
    function automatic int nw_of(input int which);
        return 4 * (which + 7);
    endfunction

    function automatic logic [31:0] get_word(input int which, input int k);
        case (which)
            4:       return out4[32*NW4-1-32*k -: 32];
            6:       return out6[32*NW6-1-32*k -: 32];
            default: return out8[32*NW8-1-32*k -: 32];
        endcase
    endfunction

    function automatic logic [255:0] cur_key(input int which);
        case (which)
            4:       return {128'h0, key4};
            6:       return {64'h0, key6};
            default: return key8;
        endcase
    endfunction

    task automatic push_sched(input int which, input logic [255:0] k, input string tag);
        logic [31:0] w [60];
        ref_expand(which, k, w);
        for (int j = 0; j < nw_of(which); j++) sb_q.push_back('{which, j, w[j], tag});
    endtask

    task automatic push_zero(input int which, input string tag);
        for (int j = 0; j < nw_of(which); j++) sb_q.push_back('{which, j, 32'h0, tag});
    endtask

    task automatic push_round(input int which, input int r, input logic [127:0] v, input string tag);
        for (int j = 0; j < 4; j++) sb_q.push_back('{which, 4*r + j, v[127-32*j -: 32], tag});
    endtask

    // Fire the monitor and confirm it drained everything queued.
    task automatic sample();
        -> sample_ev;
        #1;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d items left, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin : monitor
        item_t it;
        logic [31:0] got;
        forever begin
            @(sample_ev);
            while (sb_q.size() != 0) begin
                it  = sb_q.pop_front();
                got = get_word(it.which, it.word);
                checks++;
                if (got !== it.exp) begin
                    errors++;
                    $display("FAIL %s nk=%0d word %0d: got %h required %h",
                             it.tag, it.which, it.word, got, it.exp);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic rand_keys();
        for (int j = 0; j < 8; j++) begin
            if (j < 4) key4[32*j +: 32] = $urandom;
            if (j < 6) key6[32*j +: 32] = $urandom;
            key8[32*j +: 32] = $urandom;
        end
    endtask

    logic [255:0] k4s, k6s, k8s;

    initial begin
        build_sbox();

        // Known-answer keys 00 01 02 ...
        for (int j = 0; j < 32; j++) begin
            if (j < 16) key4[127-8*j -: 8] = 8'(j);
            if (j < 24) key6[191-8*j -: 8] = 8'(j);
            key8[255-8*j -: 8] = 8'(j);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        push_zero(4, "reset4"); push_zero(6, "reset6"); push_zero(8, "reset8");
        sample();

        release_reset();
        // Edge 40: last word still pending, the one before just written.
        edges(40);
        begin
            logic [31:0] w [60];
            ref_expand(4, cur_key(4), w);
            sb_q.push_back('{4, 42, w[42], "partial"});
            sb_q.push_back('{4, 43, 32'h0, "pending"});
        end
        sample();
        edges(1);   // 41
        push_sched(4, cur_key(4), "kat4");
        push_round(4, 0, key4, "kat4_r0");
        push_round(4, 1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe, "kat4_r1");
        push_round(4, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "kat4_r10");
        sample();
        edges(6);   // 47
        push_sched(6, cur_key(6), "kat6");
        push_round(6, 12, 128'ha4970a331a78dc09c418c271e3a41d5d, "kat6_r12");
        sample();
        edges(6);   // 53
        push_sched(8, cur_key(8), "kat8");
        push_round(8, 2, 128'ha573c29fa176c498a97fce93a572c09c, "kat8_r2");
        push_round(8, 14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "kat8_r14");
        sample();

        // Random keys changed after load; then hold for 100 edges.
        for (int it = 0; it < 3; it++) begin
            reset = 1'b1;
            rand_keys();
            k4s = cur_key(4); k6s = cur_key(6); k8s = cur_key(8);
            edges(2);
            release_reset();
            edges(5);
            rand_keys();
            edges(48);  // 53
            push_sched(4, k4s, "keychg4"); push_sched(6, k6s, "keychg6"); push_sched(8, k8s, "keychg8");
            sample();
            if (it == 0) begin
                edges(100);
                push_sched(4, k4s, "hold4"); push_sched(6, k6s, "hold6"); push_sched(8, k8s, "hold8");
                sample();
            end
        end

        // Reset mid-expansion: clears without a clock, then regenerates.
        reset = 1'b1;
        rand_keys();
        edges(2);
        release_reset();
        repeat (20) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        push_zero(4, "async4"); push_zero(6, "async6"); push_zero(8, "async8");
        sample();
        edges(2);
        release_reset();
        edges(41);
        push_sched(4, cur_key(4), "rerun4");
        sample();
        edges(12);  // 53
        push_sched(6, cur_key(6), "rerun6"); push_sched(8, cur_key(8), "rerun8");
        sample();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
